// File: rtl/mips_pipe_pkg.sv
// Shared fetch/issue pipeline constants and the prefetch queue entry format.
package mips_pipe_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0]  PC_INCR          = 32'h4;
    localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  next_pc;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Instruction-memory, redirect and issue handshake signals of the fetch stage.
interface fetch_queue_unit_if;
    import mips_pipe_pkg::*;

    logic               imem_req_o;
    logic [ADDR_W-1:0]  imem_addr_o;
    logic [INSTR_W-1:0] imem_rdata_i;
    logic               imem_rvalid_i;
    logic               redirect_i;
    logic [ADDR_W-1:0]  redirect_pc_i;
    logic               instr_valid_o;
    logic [INSTR_W-1:0] instr_o;
    logic [ADDR_W-1:0]  next_pc_o;
    logic               iss_ready_i;

    modport master (
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, next_pc_o,
        input  imem_rdata_i, imem_rvalid_i, redirect_i, redirect_pc_i, iss_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, next_pc_o,
        output imem_rdata_i, imem_rvalid_i, redirect_i, redirect_pc_i, iss_ready_i
    );

endinterface

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {instr, next_pc} entries; the parent prevents overflow.
module fetch_fifo
    import mips_pipe_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: storage has no reset; entries are only observed once count says they were written.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: sequential PC generation, pipelined imem requests and a prefetch queue with redirect flush.
module fetch_queue_unit
    import mips_pipe_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    fetch_queue_unit_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic              kill;
    logic              req;
    logic              push;
    logic              pop;
    logic              head_valid;
    logic [CNT_W-1:0]  count;
    fetch_entry_t      push_data;
    fetch_entry_t      head_data;

    // Slots are reserved for queued plus in-flight fetches; a same-cycle pop is not
    // credited so iss_ready_i never reaches imem_req_o. Reset also masks the request.
    assign req = reset && !bus.redirect_i
              && ((count + CNT_W'(inflight)) < CNT_W'(DEPTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= RESET_PC;
            inflight    <= 1'b0;
            kill        <= 1'b0;
        end else begin
            inflight <= req;
            kill     <= bus.redirect_i && inflight;
            if (bus.redirect_i) begin
                fetch_pc <= word_align(bus.redirect_pc_i);
            end else if (req) begin
                fetch_pc    <= fetch_pc + PC_INCR;
                inflight_pc <= fetch_pc;
            end
        end
    end

    assign push              = bus.imem_rvalid_i && inflight && !kill;
    assign push_data.instr   = bus.imem_rdata_i;
    assign push_data.next_pc = inflight_pc + PC_INCR;
    assign head_valid        = (count != '0);
    assign pop               = head_valid && bus.iss_ready_i;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.redirect_i),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .count     (count)
    );

    assign bus.imem_req_o    = req;
    assign bus.imem_addr_o   = fetch_pc;
    assign bus.instr_valid_o = head_valid;
    assign bus.instr_o       = head_valid ? head_data.instr : NOP_INSTR;
    assign bus.next_pc_o     = head_valid ? head_data.next_pc : '0;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with an addr-as-data instruction memory model.
module tb_fetch_queue_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        inject = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    fetch_queue_unit_if bus ();

    fetch_queue_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory returns the request address as data, one cycle later; inject forces a stray response.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_rvalid <= 1'b0;
            mem_rdata  <= 32'h0;
        end else begin
            mem_rvalid <= bus.imem_req_o;
            mem_rdata  <= bus.imem_addr_o;
        end
    end

    assign bus.imem_rvalid_i = mem_rvalid | inject;
    assign bus.imem_rdata_i  = inject ? 32'hDEAD_BEEF : mem_rdata;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [31:0] instr, input logic [31:0] npc);
        check({tag, "_valid"}, bus.instr_valid_o, 1);
        check({tag, "_instr"}, bus.instr_o, instr);
        check({tag, "_npc"}, bus.next_pc_o, npc);
    endtask

    task automatic restart(input logic ready);
        reset = 1'b0;
        bus.redirect_i = 1'b0;
        step();
        step();
        bus.iss_ready_i = ready;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.iss_ready_i   = 1'b1;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;

        // Reset values, then streaming with ready held high.
        step();
        step();
        check("rst_req", bus.imem_req_o, 0);
        check("rst_addr", bus.imem_addr_o, 32'h0);
        check("rst_valid", bus.instr_valid_o, 0);
        check("rst_instr", bus.instr_o, 0);
        check("rst_npc", bus.next_pc_o, 0);
        reset = 1'b1;
        #1;
        check("t1_req_c1", bus.imem_req_o, 1);
        check("t1_addr_c1", bus.imem_addr_o, 32'h0);
        step();
        check("t1_addr_c2", bus.imem_addr_o, 32'h4);
        check("t1_valid_c2", bus.instr_valid_o, 0);
        step();
        check("t1_addr_c3", bus.imem_addr_o, 32'h8);
        check_head("t1_c3", 32'h0, 32'h4);
        for (int k = 1; k <= 3; k++) begin
            step();
            check_head("t1_stream", 32'(4 * k), 32'(4 * k + 4));
        end

        // Issue stall: queue fills to DEPTH, then drains in order.
        restart(1'b0);
        for (int i = 0; i < 4; i++) begin
            check("t2_req", bus.imem_req_o, 1);
            check("t2_addr", bus.imem_addr_o, 32'(4 * i));
            step();
        end
        check("t2_req_full_c5", bus.imem_req_o, 0);
        step();
        check("t2_req_full_c6", bus.imem_req_o, 0);
        check_head("t2_hold", 32'h0, 32'h4);
        bus.iss_ready_i = 1'b1;
        step();
        check("t2_resume_req", bus.imem_req_o, 1);
        check("t2_resume_addr", bus.imem_addr_o, 32'h10);
        check_head("t2_pop4", 32'h4, 32'h8);
        step();
        check_head("t2_pop8", 32'h8, 32'hC);
        step();
        check_head("t2_popC", 32'hC, 32'h10);
        step();
        check_head("t2_pop10", 32'h10, 32'h14);

        // Redirect with two entries queued and the fetch of 8 in flight.
        restart(1'b0);
        step();
        step();
        step();
        check_head("t3_pre", 32'h0, 32'h4);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0103;
        #1;
        check("t3_req_redir", bus.imem_req_o, 0);
        step();
        bus.redirect_i = 1'b0;
        #1;
        check("t3_valid_flushed", bus.instr_valid_o, 0);
        check("t3_req_after", bus.imem_req_o, 1);
        check("t3_addr_after", bus.imem_addr_o, 32'h100);
        step();
        check("t3_valid_c6", bus.instr_valid_o, 0);
        step();
        check_head("t3_first", 32'h100, 32'h104);

        // Reservation full (3 queued + 1 in flight); push and pop in the same cycle.
        restart(1'b0);
        step();
        step();
        step();
        step();
        check("t4_req_full", bus.imem_req_o, 0);
        check_head("t4_head0", 32'h0, 32'h4);
        bus.iss_ready_i = 1'b1;
        step();
        check("t4_req_resume", bus.imem_req_o, 1);
        check("t4_addr_resume", bus.imem_addr_o, 32'h10);
        check_head("t4_head4", 32'h4, 32'h8);
        for (int k = 2; k <= 4; k++) begin
            step();
            check_head("t4_order", 32'(4 * k), 32'(4 * k + 4));
        end

        // Back-to-back redirects, the last one lands on the top word and the PC wraps.
        restart(1'b1);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0200;
        #1;
        check("t5_req_redir1", bus.imem_req_o, 0);
        step();
        bus.redirect_pc_i = 32'hFFFF_FFFE;
        #1;
        check("t5_req_redir2", bus.imem_req_o, 0);
        step();
        bus.redirect_i = 1'b0;
        #1;
        check("t5_req_top", bus.imem_req_o, 1);
        check("t5_addr_top", bus.imem_addr_o, 32'hFFFF_FFFC);
        step();
        check("t5_addr_wrap", bus.imem_addr_o, 32'h0);
        check("t5_valid_c4", bus.instr_valid_o, 0);
        step();
        check_head("t5_top_entry", 32'hFFFF_FFFC, 32'h0);
        step();
        check_head("t5_wrap_entry", 32'h0, 32'h4);

        // Asynchronous reset mid-stream, then a stray response after release.
        reset = 1'b0;
        #2;
        check("t6_req", bus.imem_req_o, 0);
        check("t6_addr", bus.imem_addr_o, 32'h0);
        check("t6_valid", bus.instr_valid_o, 0);
        check("t6_instr", bus.instr_o, 0);
        check("t6_npc", bus.next_pc_o, 0);
        step();
        reset  = 1'b1;
        inject = 1'b1;
        #1;
        check("t6_req_rel", bus.imem_req_o, 1);
        check("t6_addr_rel", bus.imem_addr_o, 32'h0);
        step();
        inject = 1'b0;
        #1;
        check("t6_addr_c2", bus.imem_addr_o, 32'h4);
        check("t6_stray_ignored", bus.instr_valid_o, 0);
        step();
        check_head("t6_restart", 32'h0, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
